// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SD frame scheduler.
package sd_pkg;

  // Storage geometry: 512-byte sectors, 1936x1088 frames of 16-bit pixels.
  localparam int unsigned SECTOR_BYTES  = 512;
  localparam int unsigned FRAME_W       = 1936;
  localparam int unsigned FRAME_H       = 1088;
  localparam int unsigned BYTES_PER_PIX = 2;

  // Whole sectors needed per frame (rounded up; 8228 for this geometry).
  localparam int unsigned SECTORS_PER_FRAME_DEF =
    (FRAME_W * FRAME_H * BYTES_PER_PIX + SECTOR_BYTES - 1) / SECTOR_BYTES;

  // Card layout: start sectors of the two recorded sequences.
  localparam int unsigned DAY_BASE_DEF   = 24832;
  localparam int unsigned NIGHT_BASE_DEF = 1505920;

  // Default read watchdog: 2^26 cycles per frame.
  localparam int unsigned TIMEOUT_CYC_DEF = 32'd1 << 26;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_ACTIVE    = 3'd3,
    ST_NEXT      = 3'd4,
    ST_HOLD      = 3'd5
  } sd_state_e;

endpackage

// File: rtl/sd_wdog_cnt.sv
// Read watchdog: counts cycles while enabled, flags the last allowed cycle.
module sd_wdog_cnt
  import sd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  // Count 0 is the first enabled cycle, so the last allowed one is TIMEOUT_CYC-1.
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  // Cycle counter: held at zero while cleared, saturates once expired.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (enable && !expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired = enable && (r_cnt == C_LAST);

endmodule

// File: rtl/sd_frame_sched.sv
// Frame read scheduler: walks a day/night frame sequence on the SD card,
// issuing one sector-aligned read per frame with back-pressure and watchdog.
module sd_frame_sched
  import sd_pkg::*;
#(
  parameter int unsigned SECTORS_PER_FRAME = SECTORS_PER_FRAME_DEF,
  parameter int unsigned NUM_FRAMES        = 180,
  parameter int unsigned DAY_BASE          = DAY_BASE_DEF,
  parameter int unsigned NIGHT_BASE        = NIGHT_BASE_DEF,
  parameter int unsigned TIMEOUT_CYC       = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        scene_sel,
  input  logic        loop_en,
  input  logic        fifo_afull,
  input  logic        sd_idle,
  input  logic        rd_done,
  output logic        rd_req,
  output logic [31:0] rd_sector,
  output logic [29:0] rd_size,
  output logic        frame_start,
  output logic [15:0] frame_idx,
  output logic        busy,
  output logic        err_timeout
);

  localparam logic [31:0] C_SPF      = 32'(SECTORS_PER_FRAME);
  localparam logic [29:0] C_RD_SIZE  = 30'(SECTORS_PER_FRAME * SECTOR_BYTES);
  localparam logic [15:0] C_LAST_IDX = 16'(NUM_FRAMES - 1);
  localparam logic [31:0] C_DAY      = 32'(DAY_BASE);
  localparam logic [31:0] C_NIGHT    = 32'(NIGHT_BASE);

  sd_state_e   r_state;
  sd_state_e   w_state_next;

  logic [31:0] r_base;        // start sector of the latched sequence
  logic [31:0] r_cur_sector;  // base + frame_idx*SECTORS_PER_FRAME, kept incrementally
  logic [31:0] r_rd_sector;
  logic [29:0] r_rd_size;
  logic [15:0] r_frame_idx;
  logic        r_stop_pend;
  logic        r_err_timeout;

  logic        w_accept_start;
  logic        w_load_rd;
  logic        w_step;
  logic        w_wrap;
  logic        w_timeout;
  logic        w_wdog_expired;

  sd_wdog_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (r_state != ST_ACTIVE),
    .enable  (r_state == ST_ACTIVE),
    .expired (w_wdog_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and the one-cycle control strobes for the datapath.
  always_comb begin
    w_state_next   = r_state;
    w_accept_start = 1'b0;
    w_load_rd      = 1'b0;
    w_step         = 1'b0;
    w_wrap         = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept_start = 1'b1;
          w_state_next   = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (sd_idle && !fifo_afull) begin
          w_load_rd    = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // A completion on the watchdog's last cycle still counts as success.
        if (rd_done) begin
          w_state_next = ST_NEXT;
        end else if (w_wdog_expired) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_NEXT: begin
        if (r_frame_idx == C_LAST_IDX) begin
          if (loop_en) begin
            w_wrap       = 1'b1;
            w_state_next = ST_HOLD;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_step       = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // A stop arriving in this very cycle is honoured as well.
        if (r_stop_pend || stop) begin
          w_state_next = ST_IDLE;
        end else if (sd_idle && !fifo_afull) begin
          w_load_rd    = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Sequence datapath: base latch, frame counter, read descriptor, flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base        <= '0;
      r_cur_sector  <= '0;
      r_rd_sector   <= '0;
      r_rd_size     <= '0;
      r_frame_idx   <= '0;
      r_stop_pend   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_accept_start) begin
        r_base       <= scene_sel ? C_NIGHT : C_DAY;
        r_cur_sector <= scene_sel ? C_NIGHT : C_DAY;
        r_frame_idx  <= '0;
      end else if (w_wrap) begin
        r_cur_sector <= r_base;
        r_frame_idx  <= '0;
      end else if (w_step) begin
        r_cur_sector <= r_cur_sector + C_SPF;
        r_frame_idx  <= r_frame_idx + 16'd1;
      end

      // Descriptor is captured on the way into ISSUE and held until the next one.
      if (w_load_rd) begin
        r_rd_sector <= r_cur_sector;
        r_rd_size   <= C_RD_SIZE;
      end

      if (w_state_next == ST_IDLE) begin
        r_stop_pend <= 1'b0;
      end else if (stop && (r_state != ST_IDLE)) begin
        r_stop_pend <= 1'b1;
      end

      if (w_accept_start) begin
        r_err_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
    end
  end

  assign rd_req      = (r_state == ST_ACTIVE);
  assign frame_start = (r_state == ST_ISSUE);
  assign busy        = (r_state != ST_IDLE);
  assign rd_sector   = r_rd_sector;
  assign rd_size     = r_rd_size;
  assign frame_idx   = r_frame_idx;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_sd_frame_sched.sv
// Self-checking bench for sd_frame_sched: two instances (long and short
// watchdog) share stimulus; expected read descriptors go through queues.
module tb_sd_frame_sched;

  localparam int unsigned SPF   = 8228;
  localparam int unsigned DAY   = 24832;
  localparam int unsigned NIGHT = 1505920;
  localparam logic [29:0] SIZE  = 30'd4212736;

  typedef struct {
    logic [31:0] sector;
    logic [29:0] size;
    logic [15:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, stop, scene_sel, loop_en, fifo_afull, sd_idle, rd_done;

  logic        a_rd_req, a_frame_start, a_busy, a_err;
  logic [31:0] a_rd_sector;
  logic [29:0] a_rd_size;
  logic [15:0] a_frame_idx;
  logic        b_rd_req, b_frame_start, b_busy, b_err;
  logic [31:0] b_rd_sector;
  logic [29:0] b_rd_size;
  logic [15:0] b_frame_idx;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sd_frame_sched #(.NUM_FRAMES(3), .TIMEOUT_CYC(1024)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .scene_sel(scene_sel),
    .loop_en(loop_en), .fifo_afull(fifo_afull), .sd_idle(sd_idle), .rd_done(rd_done),
    .rd_req(a_rd_req), .rd_sector(a_rd_sector), .rd_size(a_rd_size),
    .frame_start(a_frame_start), .frame_idx(a_frame_idx), .busy(a_busy),
    .err_timeout(a_err)
  );

  sd_frame_sched #(.NUM_FRAMES(2), .TIMEOUT_CYC(16)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .scene_sel(scene_sel),
    .loop_en(loop_en), .fifo_afull(fifo_afull), .sd_idle(sd_idle), .rd_done(rd_done),
    .rd_req(b_rd_req), .rd_sector(b_rd_sector), .rd_size(b_rd_size),
    .frame_start(b_frame_start), .frame_idx(b_frame_idx), .busy(b_busy),
    .err_timeout(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int unsigned base, input int unsigned idx);
    exp_t e;
    e.sector = 32'(base + idx * SPF);
    e.size   = SIZE;
    e.idx    = 16'(idx);
    exp_a.push_back(e);
  endtask

  task automatic push_b(input int unsigned base, input int unsigned idx);
    exp_t e;
    e.sector = 32'(base + idx * SPF);
    e.size   = SIZE;
    e.idx    = 16'(idx);
    exp_b.push_back(e);
  endtask

  // Bounded wait for a frame_start pulse on instance a (which=0) or b (which=1).
  task automatic wait_issue(input bit which, output bit got);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if ((!which && a_frame_start) || (which && b_frame_start)) got = 1'b1;
    end
  endtask

  task automatic pulse_done();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
  endtask

  task automatic reset_duts();
    rst = 1'b1; start = 1'b0; stop = 1'b0; rd_done = 1'b0;
    fifo_afull = 1'b0; sd_idle = 1'b1; loop_en = 1'b0; scene_sel = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stop = 1'b1; rd_done = 1'b1;
    scene_sel = 1'b0; loop_en = 1'b0; fifo_afull = 1'b0; sd_idle = 1'b1;
    tick();
    total++;
    if (a_busy !== 1'b0 || a_rd_req !== 1'b0 || a_frame_start !== 1'b0 || a_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: busy=%b rd_req=%b frame_start=%b err=%b, want all 0",
               a_busy, a_rd_req, a_frame_start, a_err);
    end
    total++;
    if (a_rd_sector !== 32'd0 || a_rd_size !== 30'd0 || a_frame_idx !== 16'd0) begin
      bad++;
      $display("FAIL reset_regs: sector=%0d size=%0d idx=%0d, want 0 0 0",
               a_rd_sector, a_rd_size, a_frame_idx);
    end
    start = 1'b0; stop = 1'b0; rd_done = 1'b0; rst = 1'b0;
    tick();
    total++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_start_ignored: busy a=%b b=%b, want 0", a_busy, b_busy);
    end
    $display("test_reset done");
  endtask

  // First issue of the day sequence; stop together with start must not stick.
  task automatic test_first_issue();
    exp_t e;
    bit   got;
    reset_duts();
    push_a(DAY, 0);
    push_a(DAY, 1);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    for (int f = 0; f < 2; f++) begin
      wait_issue(1'b0, got);
      total++;
      if (!got || exp_a.size() == 0) begin
        bad++;
        $display("FAIL first_issue%0d: frame_start seen=%b, want a frame_start", f, got);
      end else begin
        e = exp_a.pop_front();
        if (a_rd_sector !== e.sector || a_rd_size !== e.size || a_frame_idx !== e.idx) begin
          bad++;
          $display("FAIL first_issue%0d: sector=%0d size=%0d idx=%0d, want %0d %0d %0d",
                   f, a_rd_sector, a_rd_size, a_frame_idx, e.sector, e.size, e.idx);
        end
      end
      tick();
      total++;
      if (a_rd_req !== 1'b1 || a_frame_start !== 1'b0) begin
        bad++;
        $display("FAIL first_req_rise%0d: rd_req=%b frame_start=%b, want 1 0", f, a_rd_req, a_frame_start);
      end
      if (f == 0) begin
        repeat (5) tick();
        pulse_done();
        total++;
        if (a_rd_req !== 1'b0 || a_rd_sector !== 32'(DAY)) begin
          bad++;
          $display("FAIL first_done_drop: rd_req=%b sector=%0d, want 0 %0d", a_rd_req, a_rd_sector, DAY);
        end
      end
    end
    $display("test_first_issue done");
  endtask

  // Night sequence, three frames, no loop, rd_done 100 cycles into each read.
  task automatic test_sequence();
    exp_t e;
    bit   got;
    bit   req_low;
    bit   extra;
    reset_duts();
    scene_sel = 1'b1;
    for (int f = 0; f < 3; f++) push_a(NIGHT, f);
    start = 1'b1;
    tick();
    start = 1'b0;
    scene_sel = 1'b0;
    req_low = 1'b0;
    for (int f = 0; f < 3; f++) begin
      wait_issue(1'b0, got);
      total++;
      if (!got || exp_a.size() == 0) begin
        bad++;
        $display("FAIL seq_issue%0d: frame_start seen=%b, want a frame_start", f, got);
      end else begin
        e = exp_a.pop_front();
        if (a_rd_sector !== e.sector || a_rd_size !== e.size || a_frame_idx !== e.idx) begin
          bad++;
          $display("FAIL seq_issue%0d: sector=%0d size=%0d idx=%0d, want %0d %0d %0d",
                   f, a_rd_sector, a_rd_size, a_frame_idx, e.sector, e.size, e.idx);
        end
      end
      for (int c = 0; c < 100; c++) begin
        tick();
        if (a_rd_req !== 1'b1) req_low = 1'b1;
      end
      pulse_done();
    end
    total++;
    if (req_low) begin
      bad++;
      $display("FAIL seq_req_level: rd_req dropped during ACTIVE, want held 1");
    end
    tick();
    total++;
    if (a_busy !== 1'b0 || a_rd_req !== 1'b0) begin
      bad++;
      $display("FAIL seq_end_idle: busy=%b rd_req=%b, want 0 0", a_busy, a_rd_req);
    end
    extra = 1'b0;
    repeat (5) begin
      tick();
      if (a_frame_start) extra = 1'b1;
    end
    total++;
    if (extra || exp_a.size() != 0) begin
      bad++;
      $display("FAIL seq_no_extra: extra frame_start=%b pending expectations=%0d, want 0 0",
               extra, exp_a.size());
    end
    $display("test_sequence done");
  endtask

  // Back-pressure during HOLD; stray rd_done in HOLD must be ignored.
  task automatic test_afull_hold();
    exp_t e;
    bit   got;
    bit   early;
    reset_duts();
    push_a(DAY, 0);
    push_a(DAY, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_issue(1'b0, got);
    total++;
    if (!got || exp_a.size() == 0) begin
      bad++;
      $display("FAIL afull_issue0: frame_start seen=%b, want a frame_start", got);
    end else begin
      e = exp_a.pop_front();
      if (a_rd_sector !== e.sector || a_frame_idx !== e.idx) begin
        bad++;
        $display("FAIL afull_issue0: sector=%0d idx=%0d, want %0d %0d", a_rd_sector, a_frame_idx, e.sector, e.idx);
      end
    end
    tick();
    fifo_afull = 1'b1;
    repeat (5) tick();
    pulse_done();
    tick();
    early = 1'b0;
    for (int c = 0; c < 50; c++) begin
      rd_done = (c == 10);
      tick();
      if (a_frame_start || !a_busy) early = 1'b1;
    end
    rd_done = 1'b0;
    total++;
    if (early || a_frame_idx !== 16'd1) begin
      bad++;
      $display("FAIL afull_hold: early issue/idle=%b idx=%0d, want 0 1", early, a_frame_idx);
    end
    fifo_afull = 1'b0;
    tick();
    got = a_frame_start;
    total++;
    if (!got || exp_a.size() == 0) begin
      bad++;
      $display("FAIL afull_release: frame_start=%b one cycle after release, want 1", got);
    end else begin
      e = exp_a.pop_front();
      if (a_rd_sector !== e.sector || a_frame_idx !== e.idx) begin
        bad++;
        $display("FAIL afull_release: sector=%0d idx=%0d, want %0d %0d", a_rd_sector, a_frame_idx, e.sector, e.idx);
      end
    end
    $display("test_afull_hold done");
  endtask

  // Stop during frame 1: frame completes, no frame 2.
  task automatic test_stop();
    exp_t e;
    bit   got;
    bit   req_low;
    bit   extra;
    reset_duts();
    push_a(DAY, 0);
    push_a(DAY, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int f = 0; f < 2; f++) begin
      wait_issue(1'b0, got);
      total++;
      if (!got || exp_a.size() == 0) begin
        bad++;
        $display("FAIL stop_issue%0d: frame_start seen=%b, want a frame_start", f, got);
      end else begin
        e = exp_a.pop_front();
        if (a_rd_sector !== e.sector || a_frame_idx !== e.idx) begin
          bad++;
          $display("FAIL stop_issue%0d: sector=%0d idx=%0d, want %0d %0d", f, a_rd_sector, a_frame_idx, e.sector, e.idx);
        end
      end
      tick();
      if (f == 0) begin
        repeat (3) tick();
        pulse_done();
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    req_low = 1'b0;
    repeat (20) begin
      tick();
      if (a_rd_req !== 1'b1) req_low = 1'b1;
    end
    total++;
    if (req_low) begin
      bad++;
      $display("FAIL stop_no_abort: rd_req dropped before rd_done, want held 1");
    end
    pulse_done();
    total++;
    if (a_rd_req !== 1'b0 || a_busy !== 1'b1) begin
      bad++;
      $display("FAIL stop_next: rd_req=%b busy=%b, want 0 1", a_rd_req, a_busy);
    end
    tick();
    total++;
    if (a_busy !== 1'b1 || a_frame_start !== 1'b0 || a_frame_idx !== 16'd2) begin
      bad++;
      $display("FAIL stop_hold: busy=%b frame_start=%b idx=%0d, want 1 0 2", a_busy, a_frame_start, a_frame_idx);
    end
    tick();
    extra = 1'b0;
    repeat (5) begin
      tick();
      if (a_frame_start) extra = 1'b1;
    end
    total++;
    if (a_busy !== 1'b0 || extra) begin
      bad++;
      $display("FAIL stop_idle: busy=%b extra frame_start=%b, want 0 0", a_busy, extra);
    end
    $display("test_stop done");
  endtask

  // Short watchdog on instance b: no rd_done, timeout after 16 ACTIVE cycles.
  task automatic test_timeout();
    exp_t e;
    bit   got;
    bit   early;
    reset_duts();
    push_b(DAY, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_issue(1'b1, got);
    total++;
    if (!got || exp_b.size() == 0) begin
      bad++;
      $display("FAIL tmo_issue: frame_start seen=%b, want a frame_start", got);
    end else begin
      e = exp_b.pop_front();
      if (b_rd_sector !== e.sector || b_rd_size !== e.size || b_frame_idx !== e.idx) begin
        bad++;
        $display("FAIL tmo_issue: sector=%0d size=%0d idx=%0d, want %0d %0d %0d",
                 b_rd_sector, b_rd_size, b_frame_idx, e.sector, e.size, e.idx);
      end
    end
    tick();
    early = (b_rd_req !== 1'b1);
    repeat (15) begin
      tick();
      if (b_err !== 1'b0 || b_rd_req !== 1'b1) early = 1'b1;
    end
    total++;
    if (early) begin
      bad++;
      $display("FAIL tmo_early: err/rd_req changed before cycle 16 of ACTIVE, want err=0 rd_req=1");
    end
    tick();
    total++;
    if (b_err !== 1'b1 || b_rd_req !== 1'b0 || b_busy !== 1'b0) begin
      bad++;
      $display("FAIL tmo_fire: err=%b rd_req=%b busy=%b, want 1 0 0", b_err, b_rd_req, b_busy);
    end
    repeat (3) tick();
    total++;
    if (b_err !== 1'b1) begin
      bad++;
      $display("FAIL tmo_sticky: err=%b, want 1", b_err);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (b_err !== 1'b0 || b_busy !== 1'b1) begin
      bad++;
      $display("FAIL tmo_clear: err=%b busy=%b, want 0 1", b_err, b_busy);
    end
    $display("test_timeout done");
  endtask

  // Two-frame loop on instance b, then reset in the middle of ACTIVE.
  task automatic test_loop();
    exp_t e;
    bit   got;
    reset_duts();
    loop_en = 1'b1;
    for (int f = 0; f < 4; f++) push_b(DAY, f % 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int f = 0; f < 4; f++) begin
      wait_issue(1'b1, got);
      total++;
      if (!got || exp_b.size() == 0) begin
        bad++;
        $display("FAIL loop_issue%0d: frame_start seen=%b, want a frame_start", f, got);
      end else begin
        e = exp_b.pop_front();
        if (b_rd_sector !== e.sector || b_frame_idx !== e.idx) begin
          bad++;
          $display("FAIL loop_issue%0d: sector=%0d idx=%0d, want %0d %0d", f, b_rd_sector, b_frame_idx, e.sector, e.idx);
        end
      end
      tick();
      if (f < 3) begin
        repeat (3) tick();
        pulse_done();
      end
    end
    total++;
    if (b_rd_req !== 1'b1) begin
      bad++;
      $display("FAIL loop_active: rd_req=%b, want 1", b_rd_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (b_rd_req !== 1'b0 || b_busy !== 1'b0 || b_frame_idx !== 16'd0) begin
      bad++;
      $display("FAIL loop_rst: rd_req=%b busy=%b idx=%0d, want 0 0 0", b_rd_req, b_busy, b_frame_idx);
    end
    $display("test_loop done");
  endtask

  initial begin
    test_reset();
    test_first_issue();
    test_sequence();
    test_afull_hold();
    test_stop();
    test_timeout();
    test_loop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not finish, want completion");
    $fatal(1, "time limit");
  end

endmodule
